// File: rtl/n64_poll_controller_pkg.sv
// Shared definitions for the N64 poll controller slice.
// Provides the command bytes, line bit timing, FSM state type and a
// saturating increment used by the error counter.
package n64_poll_controller_pkg;

  typedef logic [7:0] cmd_t;

  localparam cmd_t        CMD_STATUS = 8'h00;
  localparam cmd_t        CMD_POLL   = 8'h01;
  localparam int unsigned BIT_CYCLES = 400;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWrite,
    StRead
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/n64_poll_controller_if.sv
// Bus between the poll controller and the line-level writer/reader pair.
//   wr_en         controller -> writer : one-cycle start pulse
//   wr_cmd        controller -> writer : command byte
//   wr_busy       writer -> controller : writer shifting data
//   wr_begin_read writer -> controller : command and stop bit sent
//   rd_done       reader -> controller : response captured
//   rd_data       reader -> controller : response, right-justified
//   rd_abort      controller -> reader : reset reader after a timeout
interface n64_poll_controller_if;
  import n64_poll_controller_pkg::*;

  logic        wr_en;
  cmd_t        wr_cmd;
  logic        wr_busy;
  logic        wr_begin_read;
  logic        rd_done;
  logic [31:0] rd_data;
  logic        rd_abort;

  modport master (
    output wr_en, wr_cmd, rd_abort,
    input  wr_busy, wr_begin_read, rd_done, rd_data
  );

  modport slave (
    input  wr_en, wr_cmd, rd_abort,
    output wr_busy, wr_begin_read, rd_done, rd_data
  );
endinterface

// File: rtl/n64_poll_controller_timer.sv
// Period and timeout counters for the poll controller.
//   clk, rst_n   clock, async active-low reset
//   enable       periodic operation enabled; low holds the period counter at 0
//   start        transaction start; clears both counters
//   in_txn       a transaction is in flight; the timeout counter runs
//   period_done  period counter sits at POLL_PERIOD-1
//   tmo_expire   timeout counter sits at TIMEOUT-1
module n64_poll_controller_timer #(
  parameter int unsigned POLL_PERIOD = 1666667,
  parameter int unsigned TIMEOUT     = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic start,
  input  logic in_txn,
  output logic period_done,
  output logic tmo_expire
);
  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [PW-1:0] period_q;
  logic [TW-1:0] tmo_q;

  assign period_done = (period_q == PW'(POLL_PERIOD - 1));
  assign tmo_expire  = (tmo_q == TW'(TIMEOUT - 1));

  // The period counter keeps running during a transaction and saturates, so an
  // overrunning transaction restarts as soon as the FSM is back in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      tmo_q    <= '0;
    end else begin
      if (!enable || start) begin
        period_q <= '0;
      end else if (!period_done) begin
        period_q <= period_q + PW'(1);
      end

      if (start) begin
        tmo_q <= '0;
      end else if (in_txn && !tmo_expire) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end
endmodule

// File: rtl/n64_poll_controller.sv
// N64 poll controller: probes with STATUS until the device ID matches, then
// polls periodically, latching the button word and tracking presence/errors.
//   clk, rst_n     clock, async active-low reset
//   poll_en        level enable for periodic operation
//   force_poll     pulse; start a transaction now when idle
//   bus            master side of the writer/reader bus
//   buttons        last good POLL response
//   buttons_valid  one-cycle pulse when buttons updates
//   ctrl_present   device answered the last sequence
//   err_count      failed transactions, saturating
//   busy           transaction in flight
module n64_poll_controller
  import n64_poll_controller_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1666667,
  parameter int unsigned TIMEOUT     = 20000,
  parameter int unsigned RETRY_MAX   = 3,
  parameter logic [15:0] DEV_ID      = 16'h0500
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         poll_en,
  input  logic                         force_poll,
  n64_poll_controller_if.master        bus,
  output logic [31:0]                  buttons,
  output logic                         buttons_valid,
  output logic                         ctrl_present,
  output logic [7:0]                   err_count,
  output logic                         busy
);
  localparam int unsigned RW = $clog2(RETRY_MAX + 1);

  state_e        state_q;
  logic          init_needed_q;
  logic [RW-1:0] retry_q;
  logic          wr_en_q;
  logic          rd_abort_q;
  cmd_t          wr_cmd_q;

  logic start, period_done, tmo_expire;
  logic tmo_fail, id_fail, rsp_ok, fail;

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_cmd   = wr_cmd_q;
  assign bus.rd_abort = rd_abort_q;

  n64_poll_controller_timer #(
    .POLL_PERIOD (POLL_PERIOD),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (poll_en),
    .start       (start),
    .in_txn      (state_q != StIdle),
    .period_done (period_done),
    .tmo_expire  (tmo_expire)
  );

  // A response arriving on the expiry cycle wins over the timeout.
  always_comb begin
    start    = (state_q == StIdle) && poll_en && (period_done || force_poll);
    tmo_fail = tmo_expire && (((state_q == StWrite) && !bus.wr_begin_read) ||
                              ((state_q == StRead) && !bus.rd_done));
    id_fail  = (state_q == StRead) && bus.rd_done && (wr_cmd_q == CMD_STATUS) &&
               (bus.rd_data[23:8] != DEV_ID);
    rsp_ok   = (state_q == StRead) && bus.rd_done && !id_fail;
    fail     = tmo_fail || id_fail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      init_needed_q <= 1'b1;
      retry_q       <= '0;
      wr_en_q       <= 1'b0;
      rd_abort_q    <= 1'b0;
      wr_cmd_q      <= CMD_STATUS;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      ctrl_present  <= 1'b0;
      err_count     <= '0;
      busy          <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      rd_abort_q    <= 1'b0;
      buttons_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StIssue;
            wr_en_q  <= 1'b1;
            wr_cmd_q <= init_needed_q ? CMD_STATUS : CMD_POLL;
            busy     <= 1'b1;
          end
        end
        StIssue: state_q <= StWrite;
        StWrite: begin
          if (bus.wr_begin_read) begin
            state_q <= StRead;
          end else if (tmo_fail) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            rd_abort_q <= 1'b1;
          end
        end
        StRead: begin
          if (bus.rd_done) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            if (wr_cmd_q == CMD_POLL) begin
              buttons       <= bus.rd_data;
              buttons_valid <= 1'b1;
            end
          end else if (tmo_fail) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            rd_abort_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (rsp_ok) begin
        ctrl_present <= 1'b1;
        retry_q      <= '0;
        if (wr_cmd_q == CMD_STATUS) begin
          init_needed_q <= 1'b0;
        end
      end

      if (fail) begin
        err_count <= sat_inc8(err_count);
        if (retry_q == RW'(RETRY_MAX - 1)) begin
          ctrl_present  <= 1'b0;
          init_needed_q <= 1'b1;
          retry_q       <= '0;
        end else begin
          retry_q <= retry_q + RW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_n64_poll_controller.sv
// Bench for n64_poll_controller: a writer/reader BFM answers each command with a
// randomly chosen response, a transaction-level model predicts the outcome into a
// queue, and a monitor compares each finished transaction against it.
module tb_n64_poll_controller;
  localparam int unsigned P   = 200;
  localparam int unsigned T   = 60;
  localparam int unsigned R   = 3;
  localparam logic [15:0] DEV = 16'h0500;

  localparam int K_GOOD   = 0;
  localparam int K_SILENT = 1;
  localparam int K_BAD    = 2;

  typedef struct {
    logic [7:0]  cmd;
    bit          silent;
    bit          bv;
    logic [31:0] buttons;
    logic [7:0]  err;
    bit          present;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        poll_en;
  logic        force_poll;
  logic [31:0] buttons;
  logic        buttons_valid;
  logic        ctrl_present;
  logic [7:0]  err_count;
  logic        busy;

  n64_poll_controller_if bus ();

  n64_poll_controller #(
    .POLL_PERIOD (P),
    .TIMEOUT     (T),
    .RETRY_MAX   (R),
    .DEV_ID      (DEV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .poll_en       (poll_en),
    .force_poll    (force_poll),
    .bus           (bus),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .ctrl_present  (ctrl_present),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   mode   = 1;   // 0 random, 1 good, 2 silent, 3 bad STATUS (ID 0)
  bit   spacing_en = 1'b1;
  int   done_cnt = 0;
  int   wr_cnt   = 0;
  exp_t q[$];

  // Transaction-level model state
  bit         m_init;
  int         m_retry;
  bit         m_present;
  int         m_err;
  logic [31:0] m_buttons;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_retry = 0; m_present = 1'b0; m_err = 0; m_buttons = '0;
  endtask

  task automatic model_txn(input int kind, input logic [7:0] cmd, input logic [31:0] data,
                           output exp_t e);
    bit ok;
    if (kind == K_SILENT) ok = 1'b0;
    else if (cmd == 8'h00) ok = (data[23:8] == DEV);
    else ok = 1'b1;
    e.cmd    = cmd;
    e.silent = (kind == K_SILENT);
    e.bv     = ok && (cmd == 8'h01);
    if (e.bv) m_buttons = data;
    if (ok) begin
      m_present = 1'b1;
      m_retry   = 0;
      if (cmd == 8'h00) m_init = 1'b0;
    end else begin
      m_err   = (m_err >= 255) ? 255 : m_err + 1;
      m_retry = m_retry + 1;
      if (m_retry == R) begin
        m_present = 1'b0;
        m_init    = 1'b1;
        m_retry   = 0;
      end
    end
    e.buttons = m_buttons;
    e.err     = 8'(m_err);
    e.present = m_present;
  endtask

  // Writer/reader BFM
  initial begin
    bus.wr_begin_read = 1'b0;
    bus.rd_done       = 1'b0;
    bus.rd_data       = '0;
    bus.wr_busy       = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin : bfm_txn
        int          kind;
        int          r;
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [15:0] bad_id;
        exp_t        e;
        bit          no_begin;
        cmd = m_init ? 8'h00 : 8'h01;
        case (mode)
          1: kind = K_GOOD;
          2: kind = K_SILENT;
          3: kind = K_BAD;
          default: begin
            r = $urandom_range(0, 9);
            kind = (r < 2) ? K_SILENT : ((r < 4) ? K_BAD : K_GOOD);
          end
        endcase
        if (cmd == 8'h00) begin
          bad_id = 16'($urandom);
          if (bad_id == DEV) bad_id = ~bad_id;
          if (kind == K_BAD) data = (mode == 3) ? 32'h0 : {8'h00, bad_id, 8'($urandom)};
          else data = {8'h00, DEV, 8'($urandom)};
        end else begin
          data = (mode == 1) ? 32'h8000_0000 : $urandom;
        end
        model_txn(kind, cmd, data, e);
        q.push_back(e);
        bus.wr_busy = 1'b1;
        no_begin = (kind == K_SILENT) && ($urandom_range(0, 1) == 1);
        if (!no_begin) begin
          repeat ($urandom_range(3, 15)) @(posedge clk);
          #1;
          bus.wr_begin_read = 1'b1;
          bus.wr_busy = 1'b0;
          @(posedge clk); #1;
          bus.wr_begin_read = 1'b0;
          if (kind != K_SILENT) begin
            repeat ($urandom_range(3, 20)) @(posedge clk);
            #1;
            bus.rd_data = data;
            bus.rd_done = 1'b1;
            @(posedge clk); #1;
            bus.rd_done = 1'b0;
          end
        end else begin
          bus.wr_busy = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit         busy_prev = 1'b0;
    bit         prev_valid = 1'b0;
    int         prev_cyc = 0;
    int         wr_cyc = 0;
    logic [7:0] cur_cmd = '0;
    bit         saw_abort = 1'b0;
    int         bv_cnt = 0;
    exp_t       e;
    forever begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1) begin
        busy_prev  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (!poll_en || !spacing_en) prev_valid = 1'b0;
        if (bus.wr_en === 1'b1) begin
          wr_cnt++;
          if (prev_valid) check("wr_en spacing", cyc - prev_cyc, P);
          prev_valid = 1'b1;
          prev_cyc   = cyc;
          wr_cyc     = cyc;
          cur_cmd    = bus.wr_cmd;
          saw_abort  = 1'b0;
          bv_cnt     = 0;
          check("busy at wr_en", busy, 1);
        end
        if (buttons_valid === 1'b1) bv_cnt++;
        if (bus.rd_abort === 1'b1) begin
          saw_abort = 1'b1;
          check("rd_abort latency", cyc - wr_cyc, T);
        end
        if (busy_prev && busy === 1'b0) begin
          done_cnt++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected transaction: got cmd 0x%0h, expected none", cur_cmd);
          end else begin
            e = q.pop_front();
            check("wr_cmd", cur_cmd, e.cmd);
            check("rd_abort seen", saw_abort, e.silent);
            check("buttons_valid pulses", bv_cnt, e.bv);
            check("buttons", buttons, e.buttons);
            check("err_count", err_count, e.err);
            check("ctrl_present", ctrl_present, e.present);
          end
        end
        busy_prev = (busy === 1'b1);
      end
    end
  end

  task automatic wait_done(input int n, input string name);
    int target = done_cnt + n;
    int budget = n * (P + T + 50) + P + 100;
    while (done_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check({name, " completed in budget"}, done_cnt >= target, 1);
  endtask

  task automatic wait_begin_read(input string name);
    int budget = 2 * P + 200;
    bit seen = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge clk);
      seen = (bus.wr_begin_read === 1'b1);
      budget--;
    end
    check({name, " saw wr_begin_read"}, seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_en"}, bus.wr_en, 0);
    check({tag, " wr_cmd"}, bus.wr_cmd, 0);
    check({tag, " rd_abort"}, bus.rd_abort, 0);
    check({tag, " buttons"}, buttons, 0);
    check({tag, " buttons_valid"}, buttons_valid, 0);
    check({tag, " ctrl_present"}, ctrl_present, 0);
    check({tag, " err_count"}, err_count, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    poll_en = 1'b0;
    force_poll = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    poll_en = 1'b1;

    // STATUS probe then POLLs with a fixed button word
    mode = 1;
    wait_done(3, "probe and poll");

    // Silent line: three failures drop presence and re-arm the probe
    mode = 2;
    wait_done(3, "silent");

    // STATUS with wrong ID fails and keeps probing
    mode = 3;
    wait_done(1, "bad status");
    mode = 1;
    wait_done(2, "recovery");

    // force_poll mid-period, then poll_en drop during READ
    spacing_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    force_poll = 1'b1;
    @(posedge clk); #1;
    force_poll = 1'b0;
    check("force_poll wr_en latency", bus.wr_en, 1);
    wait_begin_read("force txn");
    @(negedge clk) poll_en = 1'b0;
    wait_done(1, "txn after poll_en drop");
    snap = wr_cnt;
    repeat (P) @(posedge clk);
    #1;
    force_poll = 1'b1;
    @(posedge clk); #1;
    force_poll = 1'b0;
    repeat (P) @(posedge clk);
    #1;
    check("no wr_en while disabled", wr_cnt, snap);
    check("idle while disabled", busy, 0);

    // Randomized traffic
    spacing_en = 1'b1;
    mode = 0;
    poll_en = 1'b1;
    wait_done(14, "random traffic");

    // Reset in the middle of READ
    mode = 1;
    wait_begin_read("pre-reset txn");
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-read reset");
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_done(2, "post-reset");

    check("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
